mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns byte-addressed pipeline requests into word
// accesses on a combinational-read data memory, with sub-word read-modify-write.
module mem_access_unit #(
    parameter int MEM_DEPTH_LOG2 = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        MERGE  = 2'b10,
        DONE_F = 2'b11
    } state_t;

    // Pick the addressed lane out of a little-endian word and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  offset,
                                                input logic        sign_ext);
        logic [31:0] shifted;
        logic [31:0] result;
        case (size)
            2'b00: begin
                shifted = word >> {offset, 3'b000};
                result  = sign_ext ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'h000000, shifted[7:0]};
            end
            2'b01: begin
                shifted = word >> {offset[1], 4'b0000};
                result  = sign_ext ? {{16{shifted[15]}}, shifted[15:0]}
                                   : {16'h0000, shifted[15:0]};
            end
            default: begin
                shifted = word;
                result  = word;
            end
        endcase
        return result;
    endfunction

    // Replace the target lane of the old memory word with right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  offset);
        logic [31:0] mask;
        logic [31:0] lane;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {offset, 3'b000};
                lane = {24'h000000, wdata[7:0]} << {offset, 3'b000};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {offset[1], 4'b0000};
                lane = {16'h0000, wdata[15:0]} << {offset[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                lane = wdata;
            end
        endcase
        return (word & ~mask) | lane;
    endfunction

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic                      write_r;
    logic [1:0]                size_r;
    logic                      signed_r;
    logic [1:0]                offset_r;
    logic [31:0]               wdata_r;
    logic [31:0]               merge_r;
    logic [MEM_DEPTH_LOG2-1:0] mem_addr_r;
    logic                      resp_valid_r;
    logic                      resp_fault_r;
    logic [31:0]               resp_rdata_r;
    logic                      fault_s;
    logic                      accept_s;
    logic                      mem_we_s;
    logic [31:0]               mem_wd_s;

    assign req_ready = (state_r == IDLE);
    assign accept_s  = req_valid && req_ready;

    // Any of these makes the request fault without touching memory.
    assign fault_s = (req_size == 2'b11)
                  || ((req_size == 2'b01) && req_address[0])
                  || ((req_size == 2'b10) && (req_address[1:0] != 2'b00))
                  || (|req_address[31:MEM_DEPTH_LOG2+2]);

    // Next-state and memory-write decode from state and latched request kind.
    always_comb begin
        state_nxt_s = state_r;
        mem_we_s    = 1'b0;
        mem_wd_s    = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = fault_s ? DONE_F : ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (write_r && (size_r == 2'b10)) begin
                    mem_we_s    = 1'b1;
                    mem_wd_s    = wdata_r;
                    state_nxt_s = IDLE;
                end else if (write_r) begin
                    state_nxt_s = MERGE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MERGE: begin
                mem_we_s    = 1'b1;
                mem_wd_s    = store_merge(merge_r, wdata_r, size_r, offset_r);
                state_nxt_s = IDLE;
            end
            DONE_F: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, latched request, merge word and registered response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            write_r      <= 1'b0;
            size_r       <= 2'b00;
            signed_r     <= 1'b0;
            offset_r     <= 2'b00;
            wdata_r      <= 32'h0000_0000;
            merge_r      <= 32'h0000_0000;
            mem_addr_r   <= '0;
            resp_valid_r <= 1'b0;
            resp_fault_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            state_r      <= state_nxt_s;
            resp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        write_r  <= req_write;
                        size_r   <= req_size;
                        signed_r <= req_signed;
                        offset_r <= req_address[1:0];
                        wdata_r  <= req_wdata;
                        // A faulting request leaves the memory address where it was.
                        if (!fault_s) begin
                            mem_addr_r <= req_address[MEM_DEPTH_LOG2+1:2];
                        end
                    end
                end
                ACCESS: begin
                    if (write_r && (size_r != 2'b10)) begin
                        merge_r <= mem_read_data;
                    end else begin
                        resp_valid_r <= 1'b1;
                        resp_fault_r <= 1'b0;
                        resp_rdata_r <= write_r ? 32'h0000_0000
                                                : load_extend(mem_read_data, size_r,
                                                              offset_r, signed_r);
                    end
                end
                MERGE: begin
                    resp_valid_r <= 1'b1;
                    resp_fault_r <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                end
                DONE_F: begin
                    resp_valid_r <= 1'b1;
                    resp_fault_r <= 1'b1;
                    resp_rdata_r <= 32'h0000_0000;
                end
                default: begin
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid       = resp_valid_r;
    assign resp_fault       = resp_fault_r;
    assign resp_rdata       = resp_rdata_r;
    assign mem_address      = {{(32-MEM_DEPTH_LOG2){1'b0}}, mem_addr_r};
    assign mem_write_enable = mem_we_s;
    assign mem_write_data   = mem_wd_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed test-plan steps plus random requests checked
// against a transaction-level model of a byte-addressed little-endian memory.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_address = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = 8'h0;
    logic [31:0] bd_data = 32'h0;

    int          n_tests = 0;
    int          n_fail = 0;
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;

    mem_access_unit #(.MEM_DEPTH_LOG2(8)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    // Data memory: combinational read, clocked write, plus a backdoor preload port.
    assign mem_read_data = mem[mem_address[7:0]];
    always @(posedge clock) begin
        if (mem_write_enable === 1'b1) mem[mem_address[7:0]] <= mem_write_data;
        else if (bd_we) mem[bd_idx] <= bd_data;
    end

    // Record every write strobe seen between clock edges.
    always @(negedge clock) begin
        if (mem_write_enable === 1'b1) begin
            wr_count     = wr_count + 1;
            last_wr_addr = mem_address;
            last_wr_data = mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clock);
        bd_idx = idx; bd_data = data; bd_we = 1'b1;
        @(negedge clock);
        bd_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    // Reference model: apply one request to ref_mem and predict the response.
    task automatic model_step(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] e_rd, output logic e_ft,
                              output int e_lat, output int e_wr);
        int          idx;
        int          off;
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        idx  = int'(a[9:2]);
        off  = int'(a[1:0]);
        word = ref_mem[idx];
        e_ft = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 0)
            || (a[31:10] != 22'd0);
        e_rd = 32'h0; e_lat = 2; e_wr = 0;
        if (!e_ft && !w) begin
            if (sz == 2'd0) begin
                b = word[8*off +: 8];
                e_rd = (sg && b >= 8'd128) ? 32'(b) - 32'd256 : 32'(b);
            end else if (sz == 2'd1) begin
                h = word[16*(off/2) +: 16];
                e_rd = (sg && h >= 16'd32768) ? 32'(h) - 32'd65536 : 32'(h);
            end else begin
                e_rd = word;
            end
        end else if (!e_ft) begin
            if (sz == 2'd0) word[8*off +: 8] = d[7:0];
            else if (sz == 2'd1) word[16*(off/2) +: 16] = d[15:0];
            else word = d;
            ref_mem[idx] = word;
            e_wr  = 1;
            e_lat = (sz == 2'd2) ? 2 : 3;
        end
    endtask

    // One request; latency counts clock cycles from the cycle the request is taken.
    task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] e_rd;
        logic        e_ft;
        int          e_lat;
        int          e_wr;
        int          wr0;
        int          n;
        int          lat;
        int          idx;
        model_step(w, sz, sg, a, d, e_rd, e_ft, e_lat, e_wr);
        idx = int'(a[9:2]);
        wr0 = wr_count;
        @(negedge clock);
        req_write = w; req_size = sz; req_signed = sg; req_address = a; req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom);
        req_address = $urandom; req_wdata = $urandom; req_signed = 1'($urandom);
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clock);
            if (resp_valid === 1'b1) lat = c;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
        chk({tag, "_rdata"}, resp_rdata, e_rd);
        chk({tag, "_fault"}, 32'(resp_fault), 32'(e_ft));
        chk({tag, "_nwrites"}, 32'(wr_count - wr0), 32'(e_wr));
        if (e_wr == 1) chk({tag, "_wr_addr"}, last_wr_addr, 32'(idx));
        chk({tag, "_mem"}, mem[idx], ref_mem[idx]);
        @(negedge clock);
        chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        chk({tag, "_hold"}, resp_rdata, e_rd);
    endtask

    logic        bw  [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0]  bsz [3] = '{2'd2, 2'd0, 2'd2};
    logic [31:0] ba  [3] = '{32'h200, 32'h201, 32'h200};
    logic [31:0] bd  [3] = '{32'hCAFEF00D, 32'h0000005A, 32'h0};

    initial begin : main
        logic [31:0] e_rd;
        logic        e_ft;
        int          e_lat;
        int          e_wr;
        int          k;
        int          pending;
        int          nresp;
        logic [31:0] last_rd;
        logic [31:0] a;

        // Reset state.
        #12;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
        chk("rst_mem_wd", mem_write_data, 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);

        // Word write then read back.
        do_req("sw150", 1'b1, 2'd2, 1'b0, 32'h150, 32'hDEADBEEF);
        chk("sw150_addr84", last_wr_addr, 32'd84);
        chk("sw150_wdata", last_wr_data, 32'hDEADBEEF);
        do_req("lw150", 1'b0, 2'd2, 1'b0, 32'h150, 32'h0);
        chk("lw150_const", resp_rdata, 32'hDEADBEEF);

        // Sub-word read-modify-write.
        poke(8'd84, 32'h11223344);
        do_req("sb152", 1'b1, 2'd0, 1'b0, 32'h152, 32'h000000AA);
        chk("sb152_wdata", last_wr_data, 32'h11AA3344);
        do_req("sh150", 1'b1, 2'd1, 1'b0, 32'h150, 32'h0000BEEF);
        chk("sh150_wdata", last_wr_data, 32'h11AABEEF);

        // Load extension.
        poke(8'h60, 32'h80FF7F01);
        do_req("lb182", 1'b0, 2'd0, 1'b1, 32'h182, 32'h0);
        chk("lb182_const", resp_rdata, 32'hFFFFFFFF);
        do_req("lbu183", 1'b0, 2'd0, 1'b0, 32'h183, 32'h0);
        chk("lbu183_const", resp_rdata, 32'h00000080);
        do_req("lh182", 1'b0, 2'd1, 1'b1, 32'h182, 32'h0);
        chk("lh182_const", resp_rdata, 32'hFFFF80FF);
        do_req("lhu180", 1'b0, 2'd1, 1'b0, 32'h180, 32'h0);
        chk("lhu180_const", resp_rdata, 32'h00007F01);

        // Faults.
        do_req("f_lw152", 1'b0, 2'd2, 1'b0, 32'h152, 32'h0);
        do_req("f_sh151", 1'b1, 2'd1, 1'b0, 32'h151, 32'h0000FFFF);
        do_req("f_size3", 1'b1, 2'd3, 1'b0, 32'h150, 32'h12345678);
        do_req("f_sw400", 1'b1, 2'd2, 1'b0, 32'h400, 32'h87654321);
        chk("f_sw400_const", 32'(resp_fault), 32'd1);

        // Back-to-back with req_valid held high.
        poke(8'h80, 32'h0);
        for (int i = 0; i < 3; i++) model_step(bw[i], bsz[i], 1'b0, ba[i], bd[i], e_rd, e_ft, e_lat, e_wr);
        k = 0; pending = 0; nresp = 0; last_rd = 32'h0;
        @(negedge clock);
        req_write = bw[0]; req_size = bsz[0]; req_signed = 1'b0;
        req_address = ba[0]; req_wdata = bd[0]; req_valid = 1'b1;
        for (int c = 0; c < 40 && (k < 3 || pending != 0); c++) begin
            if (resp_valid === 1'b1) begin
                nresp++; pending = 0; last_rd = resp_rdata;
            end
            if (k < 3) begin
                chk(pending != 0 ? "b2b_busy_ready" : "b2b_ready", 32'(req_ready),
                    pending != 0 ? 32'd0 : 32'd1);
                if (req_ready === 1'b1) begin
                    @(posedge clock);
                    #1;
                    k++; pending = 1;
                    if (k < 3) begin
                        req_write = bw[k]; req_size = bsz[k];
                        req_address = ba[k]; req_wdata = bd[k];
                    end else begin
                        req_valid = 1'b0;
                    end
                end
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        chk("b2b_nresp", 32'(nresp), 32'd3);
        chk("b2b_lw_rdata", last_rd, e_rd);
        chk("b2b_lw_const", last_rd, 32'hCAFE5A0D);
        chk("b2b_mem", mem[8'h80], ref_mem[8'h80]);

        // Reset while the merge write is pending.
        poke(8'h10, 32'h01234567);
        @(negedge clock);
        req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_address = 32'h41; req_wdata = 32'h000000EE; req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rmo_in_merge_we", 32'(mem_write_enable), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmo_we", 32'(mem_write_enable), 32'd0);
        chk("rmo_wd", mem_write_data, 32'd0);
        chk("rmo_addr", mem_address, 32'd0);
        chk("rmo_resp_valid", 32'(resp_valid), 32'd0);
        chk("rmo_rdata", resp_rdata, 32'd0);
        chk("rmo_fault", 32'(resp_fault), 32'd0);
        @(negedge clock);
        chk("rmo_mem", mem[8'h10], 32'h01234567);
        reset_n = 1'b1;
        #1;
        chk("rmo_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        chk("rmo_no_resp", 32'(resp_valid), 32'd0);
        do_req("rmo_lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

        // Random requests, mostly in range with occasional out-of-range addresses.
        for (int i = 0; i < 150; i++) begin
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) == 0) a = a | (32'h400 << $urandom_range(0, 21));
            do_req("rand", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
